// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer that cuts the ready path between pipeline stages, with flush and bubble insertion
module pipe_skid_stage #(
    parameter int                DATA_W          = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL       = '0,
    parameter bit                BUBBLE_ON_EMPTY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
    state_t            state, state_next;
    logic [DATA_W-1:0] main_data, main_next, skid_data, skid_next;
    logic              accept, take, valid_next, ready_next;
    logic [1:0]        occ_next;
    assign accept   = in_valid & in_ready;
    assign take     = out_valid & out_ready;
    assign out_data = main_data;
    // State, payload and handshake outputs all live in flops so in_ready has no path from any input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_data <= FLUSH_VAL;
            skid_data <= FLUSH_VAL;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occ       <= 2'd0;
        end else begin
            state     <= state_next;
            main_data <= main_next;
            skid_data <= skid_next;
            out_valid <= valid_next;
            in_ready  <= ready_next;
            occ       <= occ_next;
        end
    end
    // Next state and payload moves; flush overrides every handshake
    always_comb begin
        state_next = state;
        main_next  = main_data;
        skid_next  = skid_data;
        if (flush) begin
            state_next = EMPTY;
            main_next  = FLUSH_VAL;
            skid_next  = FLUSH_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_next  = in_data;
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (accept && take) begin
                        main_next = in_data;
                    end else if (accept) begin
                        skid_next  = in_data;
                        state_next = SKID;
                    end else if (take) begin
                        main_next  = BUBBLE_ON_EMPTY ? FLUSH_VAL : main_data;
                        state_next = EMPTY;
                    end
                end
                SKID: begin
                    if (take) begin
                        main_next  = skid_data;
                        state_next = FULL;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_next  = FLUSH_VAL;
                    skid_next  = FLUSH_VAL;
                end
            endcase
        end
    end
    // Handshake outputs decoded from the next state so they land in flops alongside it
    always_comb begin
        valid_next = state_next != EMPTY;
        ready_next = state_next != SKID;
        occ_next   = state_next == SKID ? 2'd2 : state_next == FULL ? 2'd1 : 2'd0;
    end
endmodule
